// File: rtl/mmio_mem_responder.sv
// Memory-side responder for the SLC-3 three-cycle fixed-wait-state protocol.
// Decodes MAR into BRAM or MMIO registers and presents aligned read data in the third cycle.
module mmio_mem_responder #(
  parameter int unsigned BRAM_AW  = 14,
  parameter logic [15:0] ADDR_HEX = 16'hFFFF,
  parameter logic [15:0] ADDR_LED = 16'hFFFE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mem_mem_ena,
  input  logic               mem_wr_ena,
  input  logic [15:0]        addr,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata,
  output logic               done,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic               bram_en,
  output logic               bram_we,
  output logic [15:0]        bram_wdata,
  input  logic [15:0]        bram_rdata,
  input  logic [15:0]        sw_i,
  output logic [15:0]        hex_o,
  output logic [15:0]        led_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, ACC3} state_t;
  typedef enum logic [1:0] {RGN_RAM, RGN_HEX, RGN_LED, RGN_UNMAP} region_t;

  state_t      state, state_nxt;
  region_t     addr_rgn, reg_tag, tag_d;
  logic        c1;
  logic [15:0] sw_meta, sw_sync, sw_cap, led_cap;

  always_comb begin
    addr_rgn = RGN_UNMAP;
    if ((addr >> BRAM_AW) == 16'h0000) addr_rgn = RGN_RAM;
    else if (addr == ADDR_HEX)         addr_rgn = RGN_HEX;
    else if (addr == ADDR_LED)         addr_rgn = RGN_LED;
  end

  // C1 is the first enabled cycle from IDLE, or the ACC3 tail restarting; gated by
  // reset so no BRAM strobe leaks out while reset is held.
  assign c1 = reset_n & mem_mem_ena & ((state == IDLE) | (state == ACC3));

  assign bram_addr  = addr[BRAM_AW-1:0];
  assign bram_wdata = wdata;
  assign bram_en    = c1 & (addr_rgn == RGN_RAM);
  assign bram_we    = bram_en & mem_wr_ena;

  // NOTE: every output of this always_comb gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    rdata     = 16'h0000;
    case (state)
      IDLE: if (mem_mem_ena) state_nxt = ACC1;
      ACC1: state_nxt = mem_mem_ena ? ACC2 : IDLE;
      ACC2: begin
        if (mem_mem_ena) begin
          state_nxt = ACC3;
          done      = 1'b1;
          case (tag_d)
            RGN_RAM:   rdata = bram_rdata;
            RGN_HEX:   rdata = sw_cap;
            RGN_LED:   rdata = led_cap;
            default:   rdata = 16'h0000;
          endcase
        end else begin
          state_nxt = IDLE;
        end
      end
      ACC3:    state_nxt = mem_mem_ena ? ACC1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      reg_tag <= RGN_UNMAP;
      tag_d   <= RGN_UNMAP;
      sw_meta <= '0;
      sw_sync <= '0;
      sw_cap  <= '0;
      led_cap <= '0;
      hex_o   <= '0;
      led_o   <= '0;
      err_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
      // The tag is delayed once more so it lines up with the BRAM output register.
      tag_d   <= reg_tag;
      if (c1) begin
        reg_tag <= addr_rgn;
        sw_cap  <= sw_sync;
        led_cap <= led_o;
        if (mem_wr_ena && addr_rgn == RGN_HEX) hex_o <= wdata;
        if (mem_wr_ena && addr_rgn == RGN_LED) led_o <= wdata;
        if (addr_rgn == RGN_UNMAP)             err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_mem_responder.sv
// Bench for mmio_mem_responder: directed vector table, corner sequences, and
// randomized requests checked against a transaction-level reference model.
module tb_mmio_mem_responder;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_mem_ena, mem_wr_ena;
  logic [15:0]   addr, wdata, rdata;
  logic          done;
  logic [AW-1:0] bram_addr;
  logic          bram_en, bram_we;
  logic [15:0]   bram_wdata;
  logic [15:0]   bram_rdata = 16'h0000;
  logic [15:0]   sw_i, hex_o, led_o;
  logic          err_o;

  always #5 clk = ~clk;

  mmio_mem_responder #(.BRAM_AW(AW), .ADDR_HEX(16'hFFFF), .ADDR_LED(16'hFFFE)) dut (
    .clk(clk), .reset_n(reset_n), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .sw_i(sw_i), .hex_o(hex_o), .led_o(led_o), .err_o(err_o)
  );

  // Synchronous read-first BRAM with an output register (two-edge read latency).
  logic [15:0] bram_mem [0:(1<<AW)-1];
  logic [15:0] bram_q1 = 16'h0000;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) bram_mem[bram_addr] <= bram_wdata;
      bram_q1 <= bram_mem[bram_addr];
    end
    bram_rdata <= bram_q1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
    end
  endtask

  // Reference model: one transaction at a time, regions decided by plain address arithmetic.
  logic [15:0] ref_mem [int];
  logic [15:0] ref_hex = 16'h0000, ref_led = 16'h0000, ref_sw = 16'h0000;
  logic        ref_err = 1'b0;

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic model_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                           output logic [15:0] exp_rd, output int exp_we, output int exp_en);
    exp_we = 0;
    exp_en = 0;
    if (int'(a) < (1 << AW)) begin
      exp_en = 1;
      exp_rd = ref_rd(int'(a));
      if (wr) begin
        exp_we = 1;
        ref_mem[int'(a)] = wd;
      end
    end else if (a == 16'hFFFF) begin
      exp_rd = ref_sw;
      if (wr) ref_hex = wd;
    end else if (a == 16'hFFFE) begin
      exp_rd = ref_led;
      if (wr) ref_led = wd;
    end else begin
      exp_rd  = 16'h0000;
      ref_err = 1'b1;
    end
  endtask

  // One three-cycle request; optionally scrambles addr/wdata/wr after C1.
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input bit scramble, output logic [15:0] rd_c3, output logic [15:0] rd_early,
                        output int n_done, output int n_we, output int n_en, output logic [15:0] hex_c2);
    n_done = 0; n_we = 0; n_en = 0; rd_early = 16'h0000; rd_c3 = 16'h0000; hex_c2 = 16'h0000;
    @(posedge clk); #1;
    mem_mem_ena = 1'b1; mem_wr_ena = wr; addr = a; wdata = wd;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (scramble) begin
          addr = 16'($urandom); wdata = 16'($urandom); mem_wr_ena = 1'($urandom);
        end
      end
      @(negedge clk);
      n_done += int'(done);
      n_we   += int'(bram_we);
      n_en   += int'(bram_en);
      if (cyc < 2)  rd_early |= rdata;
      if (cyc == 1) hex_c2 = hex_o;
      if (cyc == 2) rd_c3 = rdata;
    end
    @(posedge clk); #1;
    mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] a, wd, sw, exp_rd, exp_hex, exp_led;
    logic        exp_err;
    int          exp_we, exp_en;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] got_rd, got_early, got_hex, exp_rd, m_rd;
  int          got_done, got_we, got_en, exp_we, exp_en, m_we, m_en;
  logic [5:0]  done_bits;
  logic [15:0] rd_seq [6];

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1, 1};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 0, 1};
    vecs[2]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 16'hFFFF, 16'hCAFE, 16'hBEEF, 16'hBEEF, 16'hCAFE, 16'h0000, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 16'hFFFE, 16'h00A5, 16'hBEEF, 16'h0000, 16'hCAFE, 16'h00A5, 1'b0, 0, 0};
    vecs[5]  = '{1'b0, 16'hFFFE, 16'h0000, 16'hBEEF, 16'h00A5, 16'hCAFE, 16'h00A5, 1'b0, 0, 0};
    vecs[6]  = '{1'b1, 16'h3FFF, 16'hA1A1, 16'hBEEF, 16'h0000, 16'hCAFE, 16'h00A5, 1'b0, 1, 1};
    vecs[7]  = '{1'b0, 16'h3FFF, 16'h0000, 16'hBEEF, 16'hA1A1, 16'hCAFE, 16'h00A5, 1'b0, 0, 1};
    vecs[8]  = '{1'b0, 16'h8000, 16'h0000, 16'hBEEF, 16'h0000, 16'hCAFE, 16'h00A5, 1'b1, 0, 0};
    vecs[9]  = '{1'b1, 16'h8000, 16'h5555, 16'hBEEF, 16'h0000, 16'hCAFE, 16'h00A5, 1'b1, 0, 0};
    vecs[10] = '{1'b0, 16'h4000, 16'h0000, 16'hBEEF, 16'h0000, 16'hCAFE, 16'h00A5, 1'b1, 0, 0};

    for (int i = 0; i < (1 << AW); i++) bram_mem[i] = 16'h0000;
    reset_n = 1'b0; mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    addr = 16'h0000; wdata = 16'h0000; sw_i = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_done", {15'h0, done}, 16'h0000);
    check("reset_bram_en", {15'h0, bram_en}, 16'h0000);
    check("reset_bram_we", {15'h0, bram_we}, 16'h0000);
    check("reset_hex", hex_o, 16'h0000);
    check("reset_led", led_o, 16'h0000);
    check("reset_err", {15'h0, err_o}, 16'h0000);

    // Directed table: fixed expectations, model kept in step for later phases.
    foreach (vecs[i]) begin
      sw_i = vecs[i].sw;
      repeat (3) @(posedge clk);
      ref_sw = sw_i;
      model_req(vecs[i].wr, vecs[i].a, vecs[i].wd, m_rd, m_we, m_en);
      do_req(vecs[i].wr, vecs[i].a, vecs[i].wd, 1'b0, got_rd, got_early, got_done, got_we, got_en, got_hex);
      check($sformatf("vec%0d_rdata", i), got_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_rdata_early", i), got_early, 16'h0000);
      check($sformatf("vec%0d_done", i), 16'(got_done), 16'd1);
      check($sformatf("vec%0d_we", i), 16'(got_we), 16'(vecs[i].exp_we));
      check($sformatf("vec%0d_en", i), 16'(got_en), 16'(vecs[i].exp_en));
      check($sformatf("vec%0d_hex", i), got_hex, vecs[i].exp_hex);
      check($sformatf("vec%0d_led", i), led_o, vecs[i].exp_led);
      check($sformatf("vec%0d_err", i), {15'h0, err_o}, {15'h0, vecs[i].exp_err});
    end

    // Abort: enable for two cycles only.
    done_bits = '0;
    got_early = 16'h0000;
    @(posedge clk); #1;
    mem_mem_ena = 1'b1; mem_wr_ena = 1'b0; addr = 16'hFFFF;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (cyc == 2) mem_mem_ena = 1'b0;
      end
      @(negedge clk);
      done_bits[cyc] = done;
      got_early |= rdata;
    end
    check("abort_done", {10'h0, done_bits}, 16'h0000);
    check("abort_rdata", got_early, 16'h0000);

    // Back-to-back: enable held six cycles, reading 0x0001 then 0x0002.
    model_req(1'b1, 16'h0001, 16'h1111, m_rd, m_we, m_en);
    do_req(1'b1, 16'h0001, 16'h1111, 1'b0, got_rd, got_early, got_done, got_we, got_en, got_hex);
    model_req(1'b1, 16'h0002, 16'h2222, m_rd, m_we, m_en);
    do_req(1'b1, 16'h0002, 16'h2222, 1'b0, got_rd, got_early, got_done, got_we, got_en, got_hex);
    done_bits = '0;
    @(posedge clk); #1;
    mem_mem_ena = 1'b1; mem_wr_ena = 1'b0; addr = 16'h0001;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (cyc == 3) addr = 16'h0002;
      end
      @(negedge clk);
      done_bits[cyc] = done;
      rd_seq[cyc] = rdata;
    end
    @(posedge clk); #1;
    mem_mem_ena = 1'b0;
    check("b2b_done", {10'h0, done_bits}, 16'h0024);
    check("b2b_rdata1", rd_seq[2], ref_rd(1));
    check("b2b_rdata2", rd_seq[5], ref_rd(2));

    // Randomized requests against the model, inputs scrambled after C1.
    for (int n = 0; n < 200; n++) begin
      logic        wr;
      logic [15:0] a, wd;
      int          kind;
      if ($urandom_range(0, 3) == 0) begin
        sw_i = 16'($urandom);
        repeat (3) @(posedge clk);
      end
      ref_sw = sw_i;
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1, 2: a = 16'($urandom_range(0, 15));
        3:       a = 16'hFFFF;
        4:       a = 16'hFFFE;
        default: a = 16'($urandom_range(16'h4000, 16'hFFFD));
      endcase
      wr = 1'($urandom);
      wd = 16'($urandom);
      model_req(wr, a, wd, exp_rd, exp_we, exp_en);
      do_req(wr, a, wd, 1'b1, got_rd, got_early, got_done, got_we, got_en, got_hex);
      check($sformatf("rnd%0d_rdata", n), got_rd, exp_rd);
      check($sformatf("rnd%0d_done", n), 16'(got_done), 16'd1);
      check($sformatf("rnd%0d_we", n), 16'(got_we), 16'(exp_we));
      check($sformatf("rnd%0d_en", n), 16'(got_en), 16'(exp_en));
      check($sformatf("rnd%0d_hex", n), got_hex, ref_hex);
      check($sformatf("rnd%0d_led", n), led_o, ref_led);
      check($sformatf("rnd%0d_err", n), {15'h0, err_o}, {15'h0, ref_err});
    end

    // Reset asserted during C1 of a RAM write, before its edge: write is suppressed.
    @(posedge clk); #1;
    mem_mem_ena = 1'b1; mem_wr_ena = 1'b1; addr = 16'h0020; wdata = 16'h7777;
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_bram_we", {15'h0, bram_we}, 16'h0000);
    check("rst_mid_bram_en", {15'h0, bram_en}, 16'h0000);
    @(posedge clk); #1;
    mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    check("rst_mid_done", {15'h0, done}, 16'h0000);
    check("rst_mid_rdata", rdata, 16'h0000);
    check("rst_mid_hex", hex_o, 16'h0000);
    check("rst_mid_led", led_o, 16'h0000);
    check("rst_mid_err", {15'h0, err_o}, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    ref_hex = 16'h0000; ref_led = 16'h0000; ref_err = 1'b0;
    repeat (3) @(posedge clk);
    model_req(1'b0, 16'h0020, 16'h0000, exp_rd, exp_we, exp_en);
    do_req(1'b0, 16'h0020, 16'h0000, 1'b0, got_rd, got_early, got_done, got_we, got_en, got_hex);
    check("rst_after_ram", got_rd, exp_rd);
    check("rst_after_done", 16'(got_done), 16'd1);
    model_req(1'b0, 16'hFFFE, 16'h0000, exp_rd, exp_we, exp_en);
    do_req(1'b0, 16'hFFFE, 16'h0000, 1'b0, got_rd, got_early, got_done, got_we, got_en, got_hex);
    check("rst_after_led", got_rd, exp_rd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
